// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register built from depth chained two-entry skid stages.
// Latency is depth cycles and throughput is one word per cycle. in_ready and out_valid are registered, and a stalled head backs up through the skid slots.
module pipe_stage_elastic #(
  parameter int data_size = 16,
  parameter int size      = 3,
  parameter int vec_count = 5,
  parameter int side_size = 98,
  parameter int depth     = 2,
  localparam int vec_w    = data_size * size * vec_count,
  localparam int occ_w    = $clog2(2 * depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [vec_w-1:0]     vec_in,
  input  logic [side_size-1:0] side_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [vec_w-1:0]     vec_out,
  output logic [side_size-1:0] side_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [occ_w-1:0]     occupancy,
  output logic [15:0]          stall_count
);
  localparam int pw = vec_w + side_size;

  logic [depth-1:0] m_vld;
  logic [depth-1:0] s_vld;
  logic [depth-1:0] m_vld_nxt;
  logic [depth-1:0] s_vld_nxt;
  logic [pw-1:0]    m_dat [depth];
  logic [occ_w-1:0] occ_nxt;

  for (genvar k = 0; k < depth; k++) begin : g_stage
    logic          up_vld;
    logic          dn_rdy;
    logic          up_fire;
    logic          dn_free;
    logic [pw-1:0] up_dat;
    logic [pw-1:0] m_q;
    logic [pw-1:0] s_q;
    logic          m_v;
    logic          s_v;
    logic          m_v_d;
    logic          s_v_d;

    if (k == 0) begin : g_in
      assign up_vld = in_valid;
      assign up_dat = {vec_in, side_in};
    end else begin : g_chain
      assign up_vld = m_vld[k-1];
      assign up_dat = m_dat[k-1];
    end

    if (k == depth - 1) begin : g_out
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = ~s_vld[k+1];
    end

    assign up_fire = up_vld & ~s_v;
    assign dn_free = ~m_v | dn_rdy;

    always_comb begin
      m_v_d = m_v;
      s_v_d = s_v;
      if (flush) begin
        m_v_d = 1'b0;
        s_v_d = 1'b0;
      end else if (dn_free) begin
        // A full skid implies m is valid, so m stays valid while it is refilled
        if (s_v) s_v_d = 1'b0;
        else     m_v_d = up_fire;
      end else if (up_fire) begin
        s_v_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_q <= '0;
        s_q <= '0;
      end else begin
        m_v <= m_v_d;
        s_v <= s_v_d;
        if (!flush && dn_free) begin
          if (s_v)          m_q <= s_q;
          else if (up_fire) m_q <= up_dat;
        end
        if (!flush && !dn_free && up_fire) s_q <= up_dat;
      end
    end

    assign m_vld[k]     = m_v;
    assign s_vld[k]     = s_v;
    assign m_vld_nxt[k] = m_v_d;
    assign s_vld_nxt[k] = s_v_d;
    assign m_dat[k]     = m_q;
  end

  // Counting next-state bits keeps the registered occupancy aligned with the current contents
  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < depth; k++) begin
      occ_nxt = occ_nxt + occ_w'(m_vld_nxt[k]) + occ_w'(s_vld_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy   <= '0;
      stall_count <= '0;
    end else begin
      occupancy <= occ_nxt;
      if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  assign in_ready            = ~s_vld[0];
  assign out_valid           = m_vld[depth-1];
  assign {vec_out, side_out} = m_dat[depth-1];

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic at depth 1, 2 and 4, with all three driven in lockstep.
// A per-stage count/queue model predicts every output on every cycle, and directed phases pin literal values on depth 2.
module tb_pipe_stage_elastic;
  localparam int VW = 240;
  localparam int SW = 98;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic flush     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  int   cur_tag   = 0;
  logic [VW-1:0] vec_in;
  logic [SW-1:0] side_in;

  logic [2:0]         ov;
  logic [2:0]         ir;
  logic [2:0][VW-1:0] vo;
  logic [2:0][SW-1:0] so;
  logic [2:0][15:0]   sc;
  logic [1:0]         occ1;
  logic [2:0]         occ2;
  logic [3:0]         occ4;
  int                 occ_a [3];

  int total = 0;
  int bad   = 0;
  logic abcd_seen = 1'b0;

  int dep [3] = '{1, 2, 4};
  int cnt [3][5];
  int ring[3][16];
  int rh  [3];
  int rn  [3];
  int mst [3];

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk_vec(input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int e = 0; e < 15; e++) v[16*e +: 16] = 16'(t) ^ 16'(e << 12);
    return v;
  endfunction

  function automatic logic [SW-1:0] mk_side(input int t);
    logic [31:0] u;
    u = t;
    return {2'b01, u, ~u, u * 32'd3};
  endfunction

  assign vec_in  = mk_vec(cur_tag);
  assign side_in = mk_side(cur_tag);

  always_comb begin
    occ_a[0] = int'(occ1);
    occ_a[1] = int'(occ2);
    occ_a[2] = int'(occ4);
  end

  pipe_stage_elastic #(.depth(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .vec_in(vec_in), .side_in(side_in),
    .in_valid(in_valid), .in_ready(ir[0]), .vec_out(vo[0]), .side_out(so[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .occupancy(occ1), .stall_count(sc[0]));

  pipe_stage_elastic #(.depth(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .vec_in(vec_in), .side_in(side_in),
    .in_valid(in_valid), .in_ready(ir[1]), .vec_out(vo[1]), .side_out(so[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .occupancy(occ2), .stall_count(sc[1]));

  pipe_stage_elastic #(.depth(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .vec_in(vec_in), .side_in(side_in),
    .in_valid(in_valid), .in_ready(ir[2]), .vec_out(vo[2]), .side_out(so[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .occupancy(occ4), .stall_count(sc[2]));

  task automatic check(input string name, input int inst,
                       input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[d%0d]: got %0h expected %0h", name, dep[inst], act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: each stage is a 0..2 word buffer; words leave in arrival order from one global ring.
  task automatic model_step(input int i);
    int   d;
    logic up_v;
    logic rdy;
    logic fire [5];
    d = dep[i];
    for (int k = 0; k <= d; k++) begin
      if (k == 0) up_v = in_valid;
      else        up_v = cnt[i][k-1] > 0;
      if (k == d) rdy = out_ready;
      else        rdy = cnt[i][k] < 2;
      fire[k] = up_v && rdy;
    end
    if (cnt[i][d-1] > 0 && !out_ready && mst[i] < 65535) mst[i]++;
    if (flush) begin
      for (int k = 0; k < 5; k++) cnt[i][k] = 0;
      rn[i] = 0;
    end else begin
      for (int k = 0; k < d; k++) cnt[i][k] += int'(fire[k]) - int'(fire[k+1]);
      if (fire[0]) begin
        ring[i][(rh[i] + rn[i]) % 16] = cur_tag;
        rn[i]++;
      end
      if (fire[d]) begin
        rh[i] = (rh[i] + 1) % 16;
        rn[i]--;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 5; k++) cnt[i][k] = 0;
        rh[i] = 0; rn[i] = 0; mst[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        int   d;
        int   occ_m;
        logic mv;
        d = dep[i];
        occ_m = 0;
        for (int k = 0; k < d; k++) occ_m += cnt[i][k];
        mv = cnt[i][d-1] > 0;
        check("out_valid", i, VW'(ov[i]), VW'(mv));
        check("in_ready", i, VW'(ir[i]), VW'(cnt[i][0] < 2));
        check("occupancy", i, VW'(occ_a[i]), VW'(occ_m));
        check("stall_count", i, VW'(sc[i]), VW'(mst[i]));
        if (mv) begin
          check("vec_out", i, vo[i], mk_vec(ring[i][rh[i]]));
          check("side_out", i, VW'(so[i]), VW'(mk_side(ring[i][rh[i]])));
        end
        if (ov[i] && vo[i] == mk_vec(32'hABCD)) abcd_seen = 1'b1;
      end
    end
  end

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_out_valid"}, i, VW'(ov[i]), '0);
      check({tag, "_vec_out"}, i, vo[i], '0);
      check({tag, "_side_out"}, i, VW'(so[i]), '0);
      check({tag, "_occupancy"}, i, VW'(occ_a[i]), '0);
      check({tag, "_stall"}, i, VW'(sc[i]), '0);
      check({tag, "_in_ready"}, i, VW'(ir[i]), VW'(1'b1));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;

    // Streaming: words 1..8 back to back, out 1..8 on consecutive cycles for depth 2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cur_tag = k;
      cyc();
      if (k == 1) begin
        check("stream_first_occ", 1, VW'(occ2), VW'(3'd1));
        check("stream_first_valid", 1, VW'(ov[1]), '0);
      end else begin
        check("stream_valid", 1, VW'(ov[1]), VW'(1'b1));
        check("stream_vec", 1, vo[1], mk_vec(k - 1));
        check("stream_occ", 1, VW'(occ2), VW'(3'd2));
      end
      if (k == 2) begin
        check("stream_vec_lo", 1, VW'(vo[1][15:0]), VW'(16'h0001));
        check("stream_side_lo", 1, VW'(so[1][31:0]), VW'(32'd3));
      end
    end
    in_valid = 1'b0;
    cur_tag  = 9;
    cyc();
    check("stream_last_vec", 1, vo[1], mk_vec(8));
    check("stream_tail_occ", 1, VW'(occ2), VW'(3'd1));
    repeat (4) cyc();

    // Backpressure: out_ready low for 5 edges mid-stream
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cur_tag   = 101 + k;
      out_ready = !(k >= 3 && k < 8);
      cyc();
      if (k == 4) begin
        check("bp_full_occ", 1, VW'(occ2), VW'(3'd4));
        check("bp_full_ready", 1, VW'(ir[1]), '0);
      end
      if (k == 7) begin
        check("bp_stall", 1, VW'(sc[1]), VW'(16'd5));
        check("bp_hold_occ", 1, VW'(occ2), VW'(3'd4));
      end
      if (k == 9) check("bp_ready_back", 1, VW'(ir[1]), VW'(1'b1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    check("bp_drained", 1, VW'(occ2), '0);

    // Flush at occupancy 3 together with an offered 0xABCD word
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cur_tag = 201 + k;
      cyc();
    end
    check("fl_pre_occ", 1, VW'(occ2), VW'(3'd3));
    flush     = 1'b1;
    cur_tag   = 'hABCD;
    out_ready = 1'b1;
    cyc();
    check("fl_occ", 1, VW'(occ2), '0);
    check("fl_valid", 1, VW'(ov[1]), '0);
    check("fl_stall", 1, VW'(sc[1]), VW'(16'd6));
    check("fl_ready", 1, VW'(ir[1]), VW'(1'b1));
    flush    = 1'b0;
    in_valid = 1'b0;
    cur_tag  = 250;
    repeat (5) cyc();

    // Reset mid-stream with 3 words in flight
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cur_tag = 301 + k;
      cyc();
    end
    check("mid_pre_occ", 1, VW'(occ2), VW'(3'd3));
    #1 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Saturation: one word parked at the head with out_ready low
    in_valid = 1'b1;
    cur_tag  = 401;
    cyc();
    in_valid = 1'b0;
    repeat (65540) cyc();
    check("sat_stall", 1, VW'(sc[1]), VW'(16'hFFFF));
    repeat (3) cyc();
    check("sat_hold", 1, VW'(sc[1]), VW'(16'hFFFF));

    // Random traffic with rare flush
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(0, 99) < 60;
      out_ready = $urandom_range(0, 99) < 70;
      flush     = $urandom_range(0, 99) < 2;
      cur_tag   = 1000 + i;
      cyc();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    for (int i = 0; i < 3; i++) check("final_empty", i, VW'(occ_a[i]), '0);
    check("abcd_absent", 1, VW'(abcd_seen), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
